// File: rtl/predecode_queue.sv
// Instruction queue between fetch and decode. Each MIPS word is classified and its
// register fields are extracted on the way in, so the head entry carries them ready-made.
module predecode_queue #(
    parameter int DEPTH       = 4,
    parameter bit EN_SPECIAL2 = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instruction,
    input  logic [31:0]                in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instruction,
    output logic [31:0]                out_pc,
    output logic [4:0]                 out_regRead1,
    output logic [4:0]                 out_regRead2,
    output logic [4:0]                 out_dest,
    output logic [2:0]                 out_class,
    output logic                       out_unknown,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_LOAD   = 3'd1;
    localparam logic [2:0] CLS_STORE  = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_JUMP   = 3'd4;
    localparam logic [2:0] CLS_MULDIV = 3'd5;
    localparam logic [2:0] CLS_CP0    = 3'd6;
    localparam logic [2:0] CLS_OTHER  = 3'd7;

    typedef struct packed {
        logic [4:0] rr1;
        logic [4:0] rr2;
        logic [4:0] dest;
        logic [2:0] cls;
        logic       unknown;
    } pd_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        pd_t         pd;
    } entry_t;

    // Anything not matched below keeps the unknown/OTHER default with zeroed register fields.
    function automatic pd_t predecode(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [5:0] fn);
        pd_t d;
        d = '{5'd0, 5'd0, 5'd0, CLS_OTHER, 1'b1};
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                    6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: d = '{rs, rt, rd, CLS_ALU, 1'b0};
                    6'h00, 6'h02, 6'h03:               d = '{rt, 5'd0, rd, CLS_ALU, 1'b0};
                    6'h04, 6'h06, 6'h07:               d = '{rt, rs, rd, CLS_ALU, 1'b0};
                    6'h08:                             d = '{rs, 5'd0, 5'd0, CLS_JUMP, 1'b0};
                    6'h09:                             d = '{rs, 5'd0, rd, CLS_JUMP, 1'b0};
                    6'h18, 6'h19, 6'h1A, 6'h1B:        d = '{rs, rt, 5'd0, CLS_MULDIV, 1'b0};
                    6'h10, 6'h12:                      d = '{5'd0, 5'd0, rd, CLS_MULDIV, 1'b0};
                    6'h11, 6'h13:                      d = '{rs, 5'd0, 5'd0, CLS_MULDIV, 1'b0};
                    6'h0C:                             d = '{5'd0, 5'd0, 5'd0, CLS_OTHER, 1'b0};
                    default: ;
                endcase
            end
            6'h01: begin
                case (rt)
                    5'h00, 5'h01: d = '{rs, 5'd0, 5'd0, CLS_BRANCH, 1'b0};
                    5'h10, 5'h11: d = '{rs, 5'd0, 5'd31, CLS_BRANCH, 1'b0};
                    default: ;
                endcase
            end
            6'h02:               d = '{5'd0, 5'd0, 5'd0, CLS_JUMP, 1'b0};
            6'h03:               d = '{5'd0, 5'd0, 5'd31, CLS_JUMP, 1'b0};
            6'h04, 6'h05:        d = '{rs, rt, 5'd0, CLS_BRANCH, 1'b0};
            6'h06, 6'h07:        d = '{rs, 5'd0, 5'd0, CLS_BRANCH, 1'b0};
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: d = '{rs, 5'd0, rt, CLS_ALU, 1'b0};
            6'h10: begin
                if (rs == 5'h00)
                    d = '{5'd0, 5'd0, rt, CLS_CP0, 1'b0};
                else if (rs == 5'h04)
                    d = '{rt, 5'd0, 5'd0, CLS_CP0, 1'b0};
                else if (rs == 5'h10 && fn == 6'h18)
                    d = '{5'd0, 5'd0, 5'd0, CLS_OTHER, 1'b0};
            end
            6'h1C: begin
                if (EN_SPECIAL2 && (fn == 6'h00 || fn == 6'h01 || fn == 6'h04))
                    d = '{rs, rt, 5'd0, CLS_MULDIV, 1'b0};
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: d = '{rs, 5'd0, rt, CLS_LOAD, 1'b0};
            6'h28, 6'h29, 6'h2B:               d = '{rs, rt, 5'd0, CLS_STORE, 1'b0};
            default: ;
        endcase
        return d;
    endfunction

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    pd_t           pd_in;
    entry_t        head;
    logic          push;
    logic          pop;

    assign pd_in     = predecode(in_instruction[31:26], in_instruction[25:21],
                                 in_instruction[20:16], in_instruction[15:11],
                                 in_instruction[5:0]);
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Payload storage carries no reset; the count gates everything visible at the head.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= '{in_instruction, in_pc, pd_in};
    end

    assign head            = out_valid ? mem[rd_ptr] : '0;
    assign out_instruction = head.instr;
    assign out_pc          = head.pc;
    assign out_regRead1    = head.pd.rr1;
    assign out_regRead2    = head.pd.rr2;
    assign out_dest        = head.pd.dest;
    assign out_class       = head.pd.cls;
    assign out_unknown     = head.pd.unknown;

endmodule

// File: tb/tb_predecode_queue.sv
// Bench for predecode_queue: directed scenarios plus random traffic, checked every cycle
// against a queue model with a mask/match instruction rule table.
module tb_predecode_queue;

    localparam int DEPTH = 4;
    localparam bit EN_S2 = 1'b1;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int NO = 0, RS = 1, RT = 2, RD = 3, R31 = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, flush, out_valid, out_ready, out_unknown;
    logic [31:0]   in_instruction, in_pc, out_instruction, out_pc;
    logic [4:0]    out_regRead1, out_regRead2, out_dest;
    logic [2:0]    out_class;
    logic [CW-1:0] count;

    predecode_queue #(.DEPTH(DEPTH), .EN_SPECIAL2(EN_S2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
        .out_pc(out_pc), .out_regRead1(out_regRead1), .out_regRead2(out_regRead2),
        .out_dest(out_dest), .out_class(out_class), .out_unknown(out_unknown), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] mask; logic [31:0] match; int s1; int s2; int sd; int cls; } rule_t;
    typedef struct { logic [31:0] ins; logic [31:0] pc; } ent_t;
    typedef struct packed { logic [4:0] rr1; logic [4:0] rr2; logic [4:0] dest; logic [2:0] cls; logic unk; } exp_t;

    rule_t rules[$];
    ent_t  mq[$];
    int    checks = 0;
    int    errors = 0;
    bit    run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add_rule(input logic [31:0] mask, input logic [31:0] match,
                                     input int s1, input int s2, input int sd, input int cls);
        rule_t r;
        r.mask = mask; r.match = match; r.s1 = s1; r.s2 = s2; r.sd = sd; r.cls = cls;
        rules.push_back(r);
    endfunction

    function automatic void add_fn(input logic [5:0] op, input logic [5:0] fn,
                                   input int s1, input int s2, input int sd, input int cls);
        add_rule(32'hFC00003F, {op, 20'd0, fn}, s1, s2, sd, cls);
    endfunction

    function automatic void add_op(input logic [5:0] op, input int s1, input int s2,
                                   input int sd, input int cls);
        add_rule(32'hFC000000, {op, 26'd0}, s1, s2, sd, cls);
    endfunction

    function automatic void build_rules();
        logic [5:0] l[$];
        l = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        foreach (l[i]) add_fn(6'h00, l[i], RS, RT, RD, 0);
        l = '{6'h00, 6'h02, 6'h03};          foreach (l[i]) add_fn(6'h00, l[i], RT, NO, RD, 0);
        l = '{6'h04, 6'h06, 6'h07};          foreach (l[i]) add_fn(6'h00, l[i], RT, RS, RD, 0);
        add_fn(6'h00, 6'h08, RS, NO, NO, 4);
        add_fn(6'h00, 6'h09, RS, NO, RD, 4);
        l = '{6'h18, 6'h19, 6'h1A, 6'h1B};   foreach (l[i]) add_fn(6'h00, l[i], RS, RT, NO, 5);
        l = '{6'h10, 6'h12};                 foreach (l[i]) add_fn(6'h00, l[i], NO, NO, RD, 5);
        l = '{6'h11, 6'h13};                 foreach (l[i]) add_fn(6'h00, l[i], RS, NO, NO, 5);
        add_fn(6'h00, 6'h0C, NO, NO, NO, 7);
        add_rule(32'hFC1F0000, 32'h04000000, RS, NO, NO, 3);
        add_rule(32'hFC1F0000, 32'h04010000, RS, NO, NO, 3);
        add_rule(32'hFC1F0000, 32'h04100000, RS, NO, R31, 3);
        add_rule(32'hFC1F0000, 32'h04110000, RS, NO, R31, 3);
        add_op(6'h02, NO, NO, NO, 4);
        add_op(6'h03, NO, NO, R31, 4);
        l = '{6'h04, 6'h05};                 foreach (l[i]) add_op(l[i], RS, RT, NO, 3);
        l = '{6'h06, 6'h07};                 foreach (l[i]) add_op(l[i], RS, NO, NO, 3);
        l = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        foreach (l[i]) add_op(l[i], RS, NO, RT, 0);
        l = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25}; foreach (l[i]) add_op(l[i], RS, NO, RT, 1);
        l = '{6'h28, 6'h29, 6'h2B};          foreach (l[i]) add_op(l[i], RS, RT, NO, 2);
        add_rule(32'hFFE00000, 32'h40000000, NO, NO, RT, 6);
        add_rule(32'hFFE00000, 32'h40800000, RT, NO, NO, 6);
        add_rule(32'hFFE0003F, 32'h42000018, NO, NO, NO, 7);
        if (EN_S2) begin
            l = '{6'h00, 6'h01, 6'h04};      foreach (l[i]) add_fn(6'h1C, l[i], RS, RT, NO, 5);
        end
    endfunction

    function automatic logic [4:0] fld(input logic [31:0] w, input int sel);
        case (sel)
            RS:      return w[25:21];
            RT:      return w[20:16];
            RD:      return w[15:11];
            R31:     return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic exp_t model_decode(input logic [31:0] w);
        exp_t e;
        e = '{5'd0, 5'd0, 5'd0, 3'd7, 1'b1};
        foreach (rules[i]) begin
            if ((w & rules[i].mask) == rules[i].match) begin
                e = '{fld(w, rules[i].s1), fld(w, rules[i].s2), fld(w, rules[i].sd),
                      3'(rules[i].cls), 1'b0};
                break;
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        int k;
        if ($urandom_range(0, 3) == 0) return $urandom;
        k = $urandom_range(0, rules.size() - 1);
        return ($urandom & ~rules[k].mask) | rules[k].match;
    endfunction

    // Advance one clock, applying the queue rules to the model from the inputs presented.
    task automatic step();
        bit   push, pop;
        ent_t e;
        push  = in_valid && (mq.size() < DEPTH);
        pop   = out_ready && (mq.size() > 0);
        e.ins = in_instruction;
        e.pc  = in_pc;
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (run) begin
            exp_t e;
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
            chk("count", 32'(count), mq.size());
            if (mq.size() != 0) begin
                e = model_decode(mq[0].ins);
                chk("out_instruction", out_instruction, mq[0].ins);
                chk("out_pc", out_pc, mq[0].pc);
                chk("out_regRead1", 32'(out_regRead1), 32'(e.rr1));
                chk("out_regRead2", 32'(out_regRead2), 32'(e.rr2));
                chk("out_dest", 32'(out_dest), 32'(e.dest));
                chk("out_class", 32'(out_class), 32'(e.cls));
                chk("out_unknown", 32'(out_unknown), 32'(e.unk));
            end else begin
                chk("empty_data", out_instruction | out_pc, 32'd0);
                chk("empty_fields", {13'd0, out_regRead1, out_regRead2, out_dest,
                                     out_class, out_unknown}, 32'd0);
            end
        end
    end

    task automatic push_word(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1; in_instruction = w; in_pc = pc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] d, input logic [2:0] c, input logic u);
        chk({tag, "_rr1"}, 32'(out_regRead1), 32'(r1));
        chk({tag, "_rr2"}, 32'(out_regRead2), 32'(r2));
        chk({tag, "_dest"}, 32'(out_dest), 32'(d));
        chk({tag, "_class"}, 32'(out_class), 32'(c));
        chk({tag, "_unknown"}, 32'(out_unknown), 32'(u));
    endtask

    initial begin
        build_rules();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_instruction = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_data", out_instruction | out_pc, 32'd0);
        reset = 1'b0;
        run = 1'b1;

        // addu $3,$1,$2
        push_word(32'h00221821, 32'h100);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk_head("t1", 5'd1, 5'd2, 5'd3, 3'd0, 1'b0);
        pop_one();

        // lw $5,8($4) followed by sll $2,$3,4
        push_word(32'h8C850008, 32'h104);
        push_word(32'h00031100, 32'h108);
        chk_head("t2a", 5'd4, 5'd0, 5'd5, 3'd1, 1'b0);
        pop_one();
        chk_head("t2b", 5'd3, 5'd0, 5'd2, 3'd0, 1'b0);
        pop_one();

        push_word(32'h0C000010, 32'h10C);
        chk_head("t3_jal", 5'd0, 5'd0, 5'd31, 3'd4, 1'b0);
        pop_one();
        push_word(32'hFC000000, 32'h110);
        chk_head("t3_unk", 5'd0, 5'd0, 5'd0, 3'd7, 1'b1);
        pop_one();
        push_word(32'h70430000, 32'h114);
        chk_head("t3_madd", 5'd2, 5'd3, 5'd0, 3'd5, 1'b0);
        pop_one();

        // Fill past capacity with decode stalled, then stream through the wrap.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instruction = 32'h8C850000 + i; in_pc = 32'h200 + 4 * i;
            step();
            if (i == 3) begin
                chk("t4_full_ready", 32'(in_ready), 32'd0);
                chk("t4_full_count", 32'(count), 32'd4);
            end
        end
        chk("t4_count_after5", 32'(count), 32'd4);
        chk("t4_head", out_instruction, 32'h8C850000);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_instruction = 32'h8C850010 + i; in_pc = 32'h300 + 4 * i;
            step();
            if (i == 0) chk("t4_head_after_pop", out_instruction, 32'h8C850001);
        end
        in_valid = 1'b0; out_ready = 1'b0;

        flush = 1'b1; step(); flush = 1'b0;
        for (int i = 0; i < 3; i++) push_word(32'h00221821 + (i << 11), 32'h400 + 4 * i);
        chk("t5_count3", 32'(count), 32'd3);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instruction = 32'h00000020;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_out_data", out_instruction | out_pc, 32'd0);
        chk("t5_out_fields", {13'd0, out_regRead1, out_regRead2, out_dest, out_class,
                              out_unknown}, 32'd0);

        push_word(32'h8C850008, 32'h500);
        push_word(32'h00031100, 32'h504);
        #1;
        reset = 1'b1;
        mq.delete();
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_word(32'h0C000010, 32'h600);
        chk("t6_head_instr", out_instruction, 32'h0C000010);
        chk("t6_head_pc", out_pc, 32'h600);
        pop_one();

        for (int i = 0; i < 600; i++) begin
            in_valid       = 1'($urandom_range(0, 1));
            out_ready      = 1'($urandom_range(0, 1));
            flush          = ($urandom_range(0, 19) == 0);
            in_instruction = rand_word();
            in_pc          = $urandom;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
